// File: rtl/gcm_mem_arbiter_pkg.sv
// Shared definitions for the GCM working-memory arbiter and the crypto controller.
// Holds the arbiter state encoding and the default memory geometry.
package gcm_mem_arbiter_pkg;

    localparam int GCM_DW        = 128;
    localparam int GCM_AW        = 6;
    localparam int GCM_DEPTH     = 41;
    localparam int GCM_MAX_BURST = 8;

    localparam int REQ_C = 0;
    localparam int REQ_H = 1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN_C = 2'd1,
        ARB_OWN_H = 2'd2
    } arb_state_e;

endpackage

// File: rtl/gcm_mem_arbiter_burst_cnt.sv
// Saturating count of beats granted to the current memory owner.
// Clearing together with an increment loads 1: that beat opens the new burst.
module gcm_arb_burst_cnt #(
    parameter int MAX_BURST = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last_beat
);

    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = inc ? CW'(1) : '0;
        end else if (inc && (count_reg != CW'(MAX_BURST))) begin
            count_next = count_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // A beat granted now is the one that reaches (or is past) the burst limit.
    assign last_beat = (count_reg >= CW'(MAX_BURST - 1));

endmodule

// File: rtl/gcm_mem_arbiter.sv
// Two-requester arbiter (crypto controller / ARM host) for a single-port GCM memory.
// Bounded bursts, out-of-range detection and one-cycle read return on a shared rdata.
module gcm_mem_arbiter
    import gcm_mem_arbiter_pkg::*;
#(
    parameter int DW        = GCM_DW,
    parameter int AW        = GCM_AW,
    parameter int DEPTH     = GCM_DEPTH,
    parameter int MAX_BURST = GCM_MAX_BURST
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          c_gnt,
    output logic          h_gnt,
    output logic          c_rvalid,
    output logic          h_rvalid,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    arb_state_e    state_reg;
    arb_state_e    state_next;
    logic          c_gnt_w;
    logic          h_gnt_w;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          cnt_last;
    logic          gnt_any;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          in_range;
    logic [1:0]    gnt_vec;
    logic [1:0]    we_vec;
    logic [1:0]    rvalid_reg;
    logic          rd_done;
    logic          err_reg;
    logic [DW-1:0] rdata_hold_reg;

    gcm_arb_burst_cnt #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .inc       (cnt_inc),
        .last_beat (cnt_last)
    );

    // Grants are combinational and masked while reset is held so every
    // strobe is low for the whole reset interval.
    always_comb begin
        c_gnt_w    = 1'b0;
        h_gnt_w    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        state_next = state_reg;
        if (rst) begin
            case (state_reg)
                ARB_IDLE: begin
                    if (c_req) begin
                        c_gnt_w    = 1'b1;
                        cnt_clr    = 1'b1;
                        cnt_inc    = 1'b1;
                        state_next = ARB_OWN_C;
                    end else if (h_req) begin
                        h_gnt_w    = 1'b1;
                        cnt_clr    = 1'b1;
                        cnt_inc    = 1'b1;
                        state_next = ARB_OWN_H;
                    end
                end
                ARB_OWN_C: begin
                    if (c_req) begin
                        c_gnt_w = 1'b1;
                        if (h_req && cnt_last) begin
                            cnt_clr    = 1'b1;
                            state_next = ARB_OWN_H;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end else if (h_req) begin
                        h_gnt_w    = 1'b1;
                        cnt_clr    = 1'b1;
                        cnt_inc    = 1'b1;
                        state_next = ARB_OWN_H;
                    end else begin
                        cnt_clr    = 1'b1;
                        state_next = ARB_IDLE;
                    end
                end
                ARB_OWN_H: begin
                    if (h_req) begin
                        h_gnt_w = 1'b1;
                        if (c_req && cnt_last) begin
                            cnt_clr    = 1'b1;
                            state_next = ARB_OWN_C;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end else if (c_req) begin
                        c_gnt_w    = 1'b1;
                        cnt_clr    = 1'b1;
                        cnt_inc    = 1'b1;
                        state_next = ARB_OWN_C;
                    end else begin
                        cnt_clr    = 1'b1;
                        state_next = ARB_IDLE;
                    end
                end
                default: begin
                    cnt_clr    = 1'b1;
                    state_next = ARB_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign c_gnt   = c_gnt_w;
    assign h_gnt   = h_gnt_w;
    assign gnt_any = c_gnt_w | h_gnt_w;

    assign sel_we    = h_gnt_w ? h_we    : c_we;
    assign sel_addr  = h_gnt_w ? h_addr  : c_addr;
    assign sel_wdata = h_gnt_w ? h_wdata : c_wdata;
    assign in_range  = ({1'b0, sel_addr} < DEPTH_L);

    assign mem_en    = gnt_any & in_range;
    assign mem_we    = mem_en & sel_we;
    assign mem_addr  = gnt_any ? sel_addr  : '0;
    assign mem_wdata = gnt_any ? sel_wdata : '0;

    assign gnt_vec[REQ_C] = c_gnt_w;
    assign gnt_vec[REQ_H] = h_gnt_w;
    assign we_vec[REQ_C]  = c_we;
    assign we_vec[REQ_H]  = h_we;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rvalid
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rvalid_reg[gi] <= 1'b0;
                end else begin
                    rvalid_reg[gi] <= gnt_vec[gi] & in_range & ~we_vec[gi];
                end
            end
        end
    endgenerate

    assign c_rvalid = rvalid_reg[REQ_C];
    assign h_rvalid = rvalid_reg[REQ_H];
    assign rd_done  = |rvalid_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_reg        <= 1'b0;
            rdata_hold_reg <= '0;
        end else begin
            err_reg <= gnt_any & ~in_range;
            if (rd_done) begin
                rdata_hold_reg <= mem_rdata;
            end
        end
    end

    // Memory output passes straight through on the return cycle, then is held.
    assign rdata = rd_done ? mem_rdata : rdata_hold_reg;
    assign err   = err_reg;

endmodule

// File: tb/tb_gcm_mem_arbiter.sv
// Directed bench for gcm_mem_arbiter with a behavioural synchronous memory.
// Word i of the memory is preset to {4{32'hC0DE0000 + i}}.
module tb_gcm_mem_arbiter;

    localparam int DW = 128;
    localparam int AW = 6;

    localparam logic [DW-1:0] W3  = 128'hC0DE0003_C0DE0003_C0DE0003_C0DE0003;
    localparam logic [DW-1:0] W6  = 128'hC0DE0006_C0DE0006_C0DE0006_C0DE0006;
    localparam logic [DW-1:0] W7  = 128'hC0DE0007_C0DE0007_C0DE0007_C0DE0007;
    localparam logic [DW-1:0] WA5 = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;

    logic          clk;
    logic          rst;
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          h_req;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          c_gnt;
    logic          h_gnt;
    logic          c_rvalid;
    logic          h_rvalid;
    logic [DW-1:0] rdata;
    logic          err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [0:63];

    int vec_cnt  = 0;
    int miss_cnt = 0;

    gcm_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .h_req     (h_req),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .c_gnt     (c_gnt),
        .h_gnt     (h_gnt),
        .c_rvalid  (c_rvalid),
        .h_rvalid  (h_rvalid),
        .rdata     (rdata),
        .err       (err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= {4{32'hC0DE0000 + 32'(i)}};
            end
        end else if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("vec %-12s got=%0h ok", tag, got);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst     = 1'b0;
        c_req   = 1'b1;
        c_we    = 1'b0;
        c_addr  = '0;
        c_wdata = '0;
        h_req   = 1'b1;
        h_we    = 1'b0;
        h_addr  = '0;
        h_wdata = '0;
        mem_rdata = '0;
        #2;
        check("rst_c_gnt",  DW'(c_gnt),  '0);
        check("rst_h_gnt",  DW'(h_gnt),  '0);
        check("rst_mem_en", DW'(mem_en), '0);
        check("rst_err",    DW'(err),    '0);
        check("rst_rdata",  rdata,       '0);
        c_req = 1'b0;
        h_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Simultaneous reads from IDLE: crypto first, host next beat.
        drive_edge();
        c_req = 1'b1; c_addr = 6'd3;
        h_req = 1'b1; h_addr = 6'd7;
        @(negedge clk);
        check("both_c_gnt", DW'(c_gnt),    DW'(1));
        check("both_h_gnt", DW'(h_gnt),    '0);
        check("both_addr3", DW'(mem_addr), DW'(3));
        check("both_en",    DW'(mem_en),   DW'(1));
        drive_edge();
        c_req = 1'b0;
        @(negedge clk);
        check("sw_h_gnt",   DW'(h_gnt),    DW'(1));
        check("sw_c_gnt",   DW'(c_gnt),    '0);
        check("sw_addr7",   DW'(mem_addr), DW'(7));
        check("c_rvalid",   DW'(c_rvalid), DW'(1));
        check("rdata_w3",   rdata,         W3);
        drive_edge();
        h_req = 1'b0;
        @(negedge clk);
        check("h_rvalid",   DW'(h_rvalid), DW'(1));
        check("c_rv_low",   DW'(c_rvalid), '0);
        check("rdata_w7",   rdata,         W7);
        check("idle_gnt",   DW'(h_gnt),    '0);
        check("idle_en",    DW'(mem_en),   '0);

        // Host write then read-back of the top word.
        drive_edge();
        h_req = 1'b1; h_we = 1'b1; h_addr = 6'd40; h_wdata = WA5;
        @(negedge clk);
        check("wr_h_gnt",   DW'(h_gnt),    DW'(1));
        check("wr_mem_we",  DW'(mem_we),   DW'(1));
        check("wr_addr40",  DW'(mem_addr), DW'(40));
        check("rdata_hold", rdata,         W7);
        drive_edge();
        h_we = 1'b0;
        @(negedge clk);
        check("rd_h_gnt",   DW'(h_gnt),    DW'(1));
        check("rd_mem_we",  DW'(mem_we),   '0);
        check("wr_no_rv",   DW'(h_rvalid), '0);
        drive_edge();
        h_req = 1'b0;
        @(negedge clk);
        check("raw_rvalid", DW'(h_rvalid), DW'(1));
        check("raw_rdata",  rdata,         WA5);

        // Out-of-range crypto read.
        drive_edge();
        c_req = 1'b1; c_we = 1'b0; c_addr = 6'd45;
        @(negedge clk);
        check("oor_c_gnt",  DW'(c_gnt),    DW'(1));
        check("oor_mem_en", DW'(mem_en),   '0);
        check("oor_err_0",  DW'(err),      '0);
        drive_edge();
        c_req = 1'b0;
        @(negedge clk);
        check("oor_err",    DW'(err),      DW'(1));
        check("oor_no_rv",  DW'(c_rvalid), '0);
        drive_edge();
        @(negedge clk);
        check("oor_err_end", DW'(err),     '0);

        // Host alone: no forced switch, then crypto gets the very next beat.
        h_addr = 6'd1;
        for (int k = 0; k < 12; k++) begin
            drive_edge();
            h_req = 1'b1;
            @(negedge clk);
            check($sformatf("solo_h%0d", k), DW'(h_gnt), DW'(1));
        end
        drive_edge();
        c_req = 1'b1; c_addr = 6'd2;
        @(negedge clk);
        check("sat_h_last", DW'(h_gnt),    DW'(1));
        check("sat_c_wait", DW'(c_gnt),    '0);
        drive_edge();
        @(negedge clk);
        check("sat_c_gnt",  DW'(c_gnt),    DW'(1));
        check("sat_h_wait", DW'(h_gnt),    '0);
        drive_edge();
        c_req = 1'b0; h_req = 1'b0;
        @(negedge clk);
        check("no_req_en",  DW'(mem_en),   '0);

        // Contended bursts: 8 crypto, 8 host, 8 crypto.
        for (int k = 0; k < 24; k++) begin
            drive_edge();
            c_req = 1'b1;
            if (k >= 1) h_req = 1'b1;
            @(negedge clk);
            check($sformatf("burst_c%0d", k), DW'(c_gnt), DW'((k < 8) || (k >= 16)));
            check($sformatf("burst_h%0d", k), DW'(h_gnt), DW'((k >= 8) && (k < 16)));
        end
        drive_edge();
        c_req = 1'b0; h_req = 1'b0;
        @(negedge clk);

        // Asynchronous reset with a host read in flight.
        drive_edge();
        h_req = 1'b1; h_addr = 6'd5;
        @(negedge clk);
        check("pre_rst_h",  DW'(h_gnt),    DW'(1));
        drive_edge();
        c_req = 1'b1; c_addr = 6'd6;
        #2;
        rst = 1'b0;
        #1;
        check("ar_h_rvalid", DW'(h_rvalid), '0);
        check("ar_h_gnt",    DW'(h_gnt),    '0);
        check("ar_c_gnt",    DW'(c_gnt),    '0);
        check("ar_mem_en",   DW'(mem_en),   '0);
        check("ar_mem_we",   DW'(mem_we),   '0);
        check("ar_err",      DW'(err),      '0);
        check("ar_rdata",    rdata,         '0);
        h_req = 1'b0;
        drive_edge();
        rst = 1'b1;
        @(negedge clk);
        check("post_c_gnt",  DW'(c_gnt),    DW'(1));
        check("post_h_rv",   DW'(h_rvalid), '0);
        drive_edge();
        c_req = 1'b0;
        @(negedge clk);
        check("post_c_rv",   DW'(c_rvalid), DW'(1));
        check("post_h_rv2",  DW'(h_rvalid), '0);
        check("post_rdata",  rdata,         W6);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
